mul_arbiter: RTL and testbench
==============================

Name: mul_arbiter

Overview:
- Shares one 32x32 multiplier instance (op_start/op_clear/op_done/result handshake) between N_REQ requesters.
- Performs round-robin arbitration and latches the winner's operands.
- Sequences the multiplier through start, wait-for-done and clear.
- Returns the 64-bit product with a per-requester done pulse, or an error pulse on watchdog timeout or abort.
- Sits between requesting datapath blocks and the multiplier; the multiplier's own clk/reset_n are tied to the same nets.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles in RUN without mul_op_done before the operation is aborted (must exceed worst-case multiplier latency, 17+ cycles).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  request level per requester; held until grant.
- req_a  input  32*N_REQ  multiplicand per requester, slice i = [32*i+31:32*i].
- req_b  input  32*N_REQ  multiplier operand per requester, same slicing.
- abort  input  1  soft abort of the in-flight operation.
- grant  output  N_REQ  one-hot, one-cycle pulse: request accepted, operands sampled.
- done  output  N_REQ  one-hot, one-cycle pulse: result valid for that requester.
- err  output  N_REQ  one-hot, one-cycle pulse: operation aborted or timed out.
- result  output  64  last completed product, held until next completion.
- busy  output  1  high in RUN and CLEAR.
- mul_multiplicand  output  32  latched operand A to multiplier.
- mul_multiplier  output  32  latched operand B to multiplier.
- mul_op_start  output  1  to multiplier op_start.
- mul_op_clear  output  1  to multiplier op_clear.
- mul_result  input  64  from multiplier result.
- mul_op_done  input  1  from multiplier op_done.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr pointer=N_REQ-1, owner=0, operand regs=0, result=0, timer=0. grant/done/err/busy/mul_op_start/mul_op_clear=0.
- Multiplier contract: op_start is held high for the whole operation. op_done is level and stays high until op_clear. A one-cycle op_clear returns the multiplier to idle. Operands are stable while op_start is high.
- States: IDLE, RUN, CLEAR. mul_op_start=(state==RUN) and mul_op_clear=(state==CLEAR), both decoded from registered state only.
- IDLE:
  - If req!=0, select the first set bit searching upward from rr_ptr+1 with wrap-around.
  - Same edge: latch req_a/req_b slice to mul_multiplicand/mul_multiplier, store owner index, rr_ptr<=winner, timer<=0.
  - grant[winner]=1 in the following cycle (registered). Next state RUN.
  - req==0: stay in IDLE.
- RUN:
  - timer increments each cycle.
  - Priority 1, abort=1: err[owner] pulse, next state CLEAR, result unchanged.
  - Priority 2, else mul_op_done=1: result<=mul_result, done[owner] pulse, next state CLEAR.
  - Priority 3, else timer==TIMEOUT-1: err[owner] pulse, next state CLEAR.
  - abort beats done when both are in the same cycle.
- CLEAR: exactly one cycle, then IDLE. New requests are not accepted in CLEAR.
- Throughput: minimum 3 cycles of overhead per operation (IDLE accept, CLEAR, plus multiplier latency in RUN).
- grant, done and err are registered pulses appearing one cycle after the deciding edge. At most one bit of the three vectors combined is high in any cycle.
- Requester i must drop req[i] in the cycle it sees grant[i]. A still-high req is treated as a new request and competes fairly.
- A req asserted during RUN/CLEAR waits; no request is lost.
- abort in IDLE/CLEAR: ignored.
- mul_op_done seen outside RUN: ignored.
- Reset mid-operation: everything returns to reset values immediately. No done/err is emitted for the killed operation.

Test Plan:
- Single request: req=0001, a=0x0000_0003, b=0xFFFF_FFFD -> grant=0001, mul_op_start high until op_done, done=0001, result=0xFFFF_FFFF_FFFF_FFF7 (signed -9), one CLEAR cycle, return to IDLE.
- Round-robin fairness: req=1111 held continuously, each requester's req drops one cycle after its grant and reasserts -> grant order 0001,0010,0100,1000,0001; no starvation over 8 operations.
- Wrap-around: rr_ptr=3, req=1001 -> bit 0 granted first, then bit 3.
- Timeout: model holds mul_op_done=0 -> err[owner] exactly TIMEOUT cycles after RUN entry, mul_op_clear pulse, result unchanged, next request served.
- Abort and done in the same cycle -> err pulse only, no done, result unchanged.
- Reset mid-RUN: assert reset_n=0 asynchronously -> all outputs 0 within the same cycle, no done/err after release, next request behaves as in the first scenario.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one 32x32 multiplier
// between N_REQ requesters, with watchdog and abort handling.
module mul_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [32*N_REQ-1:0]  req_a,
   input  logic [32*N_REQ-1:0]  req_b,
   input  logic                 abort,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     done,
   output logic [N_REQ-1:0]     err,
   output logic [63:0]          result,
   output logic                 busy,
   output logic [31:0]          mul_multiplicand,
   output logic [31:0]          mul_multiplier,
   output logic                 mul_op_start,
   output logic                 mul_op_clear,
   input  logic [63:0]          mul_result,
   input  logic                 mul_op_done
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_CLEAR
   } state_e;

   state_e            state_q, state_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [31:0]       opa_q, opa_d;
   logic [31:0]       opb_q, opb_d;
   logic [63:0]       result_q, result_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [N_REQ-1:0]  done_q, done_d;
   logic [N_REQ-1:0]  err_q, err_d;

   logic              win_vld;
   logic [IW-1:0]     win_idx;

   function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Round-robin pick: first set req bit above rr_q, wrapping around
   always_comb begin : pick
      int j;
      j       = 0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         j = (int'(rr_q) + k) % N_REQ;
         if (req[j]) begin
            win_vld = 1'b1;
            win_idx = IW'(j);
         end
      end
   end

   // Next-state and pulse decode for the IDLE/RUN/CLEAR sequencer
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      owner_d  = owner_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      timer_d  = timer_q;
      grant_d  = '0;
      done_d   = '0;
      err_d    = '0;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d = S_RUN;
               opa_d   = req_a[32*win_idx +: 32];
               opb_d   = req_b[32*win_idx +: 32];
               owner_d = win_idx;
               rr_d    = win_idx;
               timer_d = '0;
               grant_d = onehot(win_idx);
            end
         end
         S_RUN: begin
            timer_d = timer_q + 1'b1;
            if (abort) begin
               err_d   = onehot(owner_q);
               state_d = S_CLEAR;
            end else if (mul_op_done) begin
               result_d = mul_result;
               done_d   = onehot(owner_q);
               state_d  = S_CLEAR;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d   = onehot(owner_q);
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, operand and pulse registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         rr_q     <= IW'(N_REQ - 1);
         owner_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         timer_q  <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         owner_q  <= owner_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         timer_q  <= timer_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign grant            = grant_q;
   assign done             = done_q;
   assign err              = err_q;
   assign result           = result_q;
   assign mul_multiplicand = opa_q;
   assign mul_multiplier   = opb_q;
   assign mul_op_start     = (state_q == S_RUN);
   assign mul_op_clear     = (state_q == S_CLEAR);
   assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard bench for mul_arbiter with a
// behavioural multi-cycle multiplier model.
module tb_mul_arbiter;

   localparam int N   = 4;
   localparam int TO  = 20;
   localparam int LAT = 17;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic            abort;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic [N-1:0]    err;
   logic [63:0]     result;
   logic            busy;
   logic [31:0]     mul_multiplicand;
   logic [31:0]     mul_multiplier;
   logic            mul_op_start;
   logic            mul_op_clear;
   logic [63:0]     mul_result;
   logic            mul_op_done;

   logic            hang;
   int              m_cnt;
   longint          cyc = 0;
   longint          evt_cyc;
   int              n_tests = 0;
   int              n_fail = 0;

   typedef struct {
      int           kind;
      logic [N-1:0] vec;
      logic [63:0]  res;
   } exp_t;

   exp_t sb[$];

   mul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req              (req),
      .req_a            (req_a),
      .req_b            (req_b),
      .abort            (abort),
      .grant            (grant),
      .done             (done),
      .err              (err),
      .result           (result),
      .busy             (busy),
      .mul_multiplicand (mul_multiplicand),
      .mul_multiplier   (mul_multiplier),
      .mul_op_start     (mul_op_start),
      .mul_op_clear     (mul_op_clear),
      .mul_result       (mul_result),
      .mul_op_done      (mul_op_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier model: signed product after LAT start cycles
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mul_op_done <= 1'b0;
         mul_result  <= '0;
         m_cnt       <= 0;
      end else if (mul_op_clear) begin
         mul_op_done <= 1'b0;
         m_cnt       <= 0;
      end else if (mul_op_start && !mul_op_done && !hang) begin
         if (m_cnt == LAT - 1) begin
            mul_op_done <= 1'b1;
            mul_result  <= $signed(mul_multiplicand) * $signed(mul_multiplier);
         end
         m_cnt <= m_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int k, input logic [N-1:0] v,
                       input logic [63:0] r);
      exp_t e;
      e.kind = k;
      e.vec  = v;
      e.res  = r;
      sb.push_back(e);
   endtask

   task automatic set_op(input int i, input logic [31:0] a,
                         input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // which: 0 grant, 1 done, 2 err
   task automatic wait_evt(input int which, input int budget);
      int c;
      bit hit;
      c   = 0;
      hit = 1'b0;
      while (!hit && c < budget) begin
         @(negedge clk);
         c++;
         if (grant != '0) req = req & ~grant;
         case (which)
            0:       hit = (grant != '0);
            1:       hit = (done != '0);
            default: hit = (err != '0);
         endcase
      end
      chk($sformatf("wait_evt%0d", which), 64'(hit), 64'd1);
      evt_cyc = cyc;
   endtask

   task automatic serve(input int budget);
      int c;
      c = 0;
      while ((req != '0 || sb.size() != 0) && c < budget) begin
         @(negedge clk);
         c++;
         if (grant != '0) req = req & ~grant;
      end
      chk("drain", 64'(req == '0 && sb.size() == 0), 64'd1);
   endtask

   // Monitor: pop and compare on every grant/done/err pulse
   initial begin
      exp_t        e;
      int          k;
      logic [N-1:0] v;
      forever begin
         @(negedge clk);
         if (reset_n && (grant | done | err) != '0) begin
            chk("onehot", 64'($countones({grant, done, err})), 64'd1);
            v = grant | done | err;
            k = (grant != '0) ? 0 : (done != '0) ? 1 : 2;
            if (sb.size() == 0) begin
               chk("unexpected_evt", 64'({grant, done, err}), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("evt_kind", 64'(k), 64'(e.kind));
               chk("evt_vec", 64'(v), 64'(e.vec));
               if (k != 0) chk("evt_result", result, e.res);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] g;
      longint       t0;
      int           c;

      reset_n = 1'b0;
      req     = '0;
      req_a   = '0;
      req_b   = '0;
      abort   = 1'b0;
      hang    = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_start", 64'(mul_op_start), 64'd0);
      chk("rst_clear", 64'(mul_op_clear), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_opa", 64'(mul_multiplicand), 64'd0);

      // Single request: 3 * -3 = -9
      set_op(0, 32'h0000_0003, 32'hFFFF_FFFD);
      push(0, 4'b0001, 64'd0);
      push(1, 4'b0001, 64'hFFFF_FFFF_FFFF_FFF7);
      req = 4'b0001;
      wait_evt(0, 10);
      chk("single_start", 64'(mul_op_start), 64'd1);
      chk("single_opa", 64'(mul_multiplicand), 64'h3);
      chk("single_opb", 64'(mul_multiplier), 64'hFFFF_FFFD);
      wait_evt(1, 40);
      chk("single_clear", 64'(mul_op_clear), 64'd1);
      chk("single_busy_clr", 64'(busy), 64'd1);
      @(negedge clk);
      chk("single_idle", 64'(busy), 64'd0);
      chk("single_clear_off", 64'(mul_op_clear), 64'd0);

      // Round-robin with all four requesting
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'h100);
      push(0, 4'b0001, 0); push(1, 4'b0001, 64'h100);
      push(0, 4'b0010, 0); push(1, 4'b0010, 64'h200);
      push(0, 4'b0100, 0); push(1, 4'b0100, 64'h300);
      push(0, 4'b1000, 0); push(1, 4'b1000, 64'h400);
      push(0, 4'b0001, 0); push(1, 4'b0001, 64'h100);
      push(0, 4'b0010, 0); push(1, 4'b0010, 64'h200);
      push(0, 4'b0100, 0); push(1, 4'b0100, 64'h300);
      push(0, 4'b1000, 0); push(1, 4'b1000, 64'h400);
      req = 4'b1111;
      for (int op = 0; op < 8; op++) begin
         wait_evt(0, 40);
         g = grant;
         if (op < 4) begin
            @(negedge clk);
            req = req | g;
         end
         wait_evt(1, 40);
      end
      serve(20);

      // Wrap-around from rr_ptr=3
      do_reset();
      set_op(0, 32'd5, 32'd7);
      set_op(3, 32'h1_0000, 32'h1_0000);
      push(0, 4'b0001, 0); push(1, 4'b0001, 64'h23);
      push(0, 4'b1000, 0); push(1, 4'b1000, 64'h1_0000_0000);
      req = 4'b1001;
      serve(200);

      // Watchdog timeout, then a normal operation
      hang = 1'b1;
      set_op(2, 32'd2, 32'd3);
      push(0, 4'b0100, 0); push(2, 4'b0100, 64'h1_0000_0000);
      req = 4'b0100;
      wait_evt(0, 10);
      t0 = evt_cyc;
      wait_evt(2, TO + 10);
      chk("timeout_latency", 64'(evt_cyc - t0), 64'(TO));
      chk("timeout_clear", 64'(mul_op_clear), 64'd1);
      chk("timeout_result", result, 64'h1_0000_0000);
      hang = 1'b0;
      set_op(1, 32'd7, 32'd6);
      push(0, 4'b0010, 0); push(1, 4'b0010, 64'h2A);
      req = 4'b0010;
      serve(100);

      // Abort in IDLE has no effect
      abort = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_busy", 64'(busy), 64'd0);

      // Abort coinciding with op_done
      set_op(3, 32'h1234, 32'h10);
      push(0, 4'b1000, 0); push(2, 4'b1000, 64'h2A);
      req = 4'b1000;
      wait_evt(0, 10);
      c = 0;
      while (!mul_op_done && c < 40) begin
         @(negedge clk);
         c++;
      end
      chk("abort_saw_done", 64'(mul_op_done), 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_err", 64'(err), 64'b1000);
      chk("abort_nodone", 64'(done), 64'd0);
      @(negedge clk);
      chk("abort_result", result, 64'h2A);
      serve(20);

      // Asynchronous reset in the middle of RUN
      set_op(0, 32'h0000_0003, 32'hFFFF_FFFD);
      push(0, 4'b0001, 0);
      req = 4'b0001;
      wait_evt(0, 10);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_start", 64'(mul_op_start), 64'd0);
      chk("mrst_result", result, 64'd0);
      chk("mrst_opa", 64'(mul_multiplicand), 64'd0);
      chk("mrst_pulses", 64'({grant, done, err}), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      push(0, 4'b0001, 0);
      push(1, 4'b0001, 64'hFFFF_FFFF_FFFF_FFF7);
      req = 4'b0001;
      serve(100);

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
